// File: rtl/traffic_src_vc_pkg.sv
// Shared defaults, FSM encoding and flit layout for the VC-aware packet injector.
// Flit layout, MSB first: {head, tail, vc, dest}.
package traffic_src_vc_pkg;

   localparam int DEF_DEPTH   = 1024;
   localparam int DEF_DEST_W  = 14;
   localparam int DEF_NUM_VC  = 4;
   localparam int DEF_NFLIT_W = 10;
   localparam int DEF_CREDITS = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic int calc_flit_w(input int vc_w, input int dest_w);
      return 2 + vc_w + dest_w;
   endfunction

   function automatic int head_bit(input int vc_w, input int dest_w);
      return 1 + vc_w + dest_w;
   endfunction

   function automatic int tail_bit(input int vc_w, input int dest_w);
      return vc_w + dest_w;
   endfunction

endpackage

// File: rtl/traffic_src_vc_credit.sv
// Per-VC saturating credit counter: loads CREDITS on clear, counts down on
// consume and up on return, flagging a return that would exceed CREDITS.
module vc_credit_ctr
   import traffic_src_vc_pkg::*;
#(
   parameter int CREDITS = DEF_CREDITS,
   parameter int CR_W    = $clog2(CREDITS + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   input  logic            dec_i,
   input  logic            inc_i,
   output logic [CR_W-1:0] count_o,
   output logic            ovf_o
);

   localparam logic [CR_W-1:0] MAX_CR = CR_W'(CREDITS);
   localparam logic [CR_W-1:0] ONE_CR = CR_W'(1);

   logic [CR_W-1:0] count_q;
   logic [CR_W-1:0] count_d;

   // Credit update; a simultaneous consume and return cancel out
   always_comb begin
      count_d = count_q;
      ovf_o   = 1'b0;
      if (clr_i) begin
         count_d = MAX_CR;
      end else if (inc_i && !dec_i) begin
         if (count_q == MAX_CR) begin
            ovf_o = 1'b1;
         end else begin
            count_d = count_q + ONE_CR;
         end
      end else if (dec_i && !inc_i) begin
         if (count_q != '0) begin
            count_d = count_q - ONE_CR;
         end else begin
            count_d = count_q;
         end
      end else begin
         count_d = count_q;
      end
   end

   // Credit register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= MAX_CR;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/traffic_src_vc.sv
// Per-node packet injector: host-loaded packet table, valid/ready flit output
// with per-VC credit flow control, start/abort control and status flags.
module traffic_src_vc
   import traffic_src_vc_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int DEST_W   = DEF_DEST_W,
   parameter int NUM_VC   = DEF_NUM_VC,
   parameter int NFLIT_W  = DEF_NFLIT_W,
   parameter int CREDITS  = DEF_CREDITS,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int VC_W    = $clog2(NUM_VC),
   localparam int CR_W    = $clog2(CREDITS + 1),
   localparam int FLIT_W  = calc_flit_w(VC_W, DEST_W)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               init_i,
   input  logic               fill_valid_i,
   input  logic [DEST_W-1:0]  fill_dest_i,
   input  logic [VC_W-1:0]    fill_vc_i,
   input  logic [NFLIT_W-1:0] fill_nflits_i,
   input  logic               start_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [FLIT_W-1:0]  out_flit_o,
   input  logic [NUM_VC-1:0]  credit_ret_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [PTR_W:0]     pkts_sent_o,
   output logic               err_o
);

   localparam int TAIL_B                = tail_bit(VC_W, DEST_W);
   localparam logic [PTR_W:0]   DEPTH_P = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   ONE_P   = (PTR_W + 1)'(1);
   localparam logic [NFLIT_W-1:0] ONE_N = NFLIT_W'(1);
   localparam logic [VC_W:0]    NUM_VC_W = (VC_W + 1)'(NUM_VC);

   logic [DEST_W-1:0]  tbl_dest_q   [0:DEPTH-1];
   logic [VC_W-1:0]    tbl_vc_q     [0:DEPTH-1];
   logic [NFLIT_W-1:0] tbl_nflits_q [0:DEPTH-1];

   state_e             state_q, state_d;
   logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
   logic [NFLIT_W-1:0] flits_left_q, flits_left_d;
   logic               out_valid_q, out_valid_d;
   logic [FLIT_W-1:0]  out_flit_q, out_flit_d;
   logic [PTR_W:0]     pkts_sent_q, pkts_sent_d;
   logic               err_q, err_d;
   logic               busy_q;
   logic               done_q;

   logic [PTR_W-1:0]   wr_idx_s;
   logic [PTR_W-1:0]   rd_idx_s;
   logic [DEST_W-1:0]  cur_dest_s;
   logic [VC_W-1:0]    cur_vc_s;
   logic [NFLIT_W-1:0] cur_nflits_s;
   logic [CR_W-1:0]    credit_cnt_s [NUM_VC];
   logic [NUM_VC-1:0]  credit_dec_s;
   logic [NUM_VC-1:0]  credit_ovf_s;
   logic               credit_ok_s;
   logic               accept_s;
   logic               tail_acc_s;
   logic               pkts_remain_s;
   logic               send_en_s;
   logic               load_s;
   logic               fill_req_s;
   logic               fill_acc_s;
   logic               fill_ovf_s;
   logic               fill_bad_vc_s;
   logic [VC_W-1:0]    fill_vc_s;
   logic [NFLIT_W-1:0] fill_nflits_s;
   logic               new_pkt_s;
   logic [NFLIT_W-1:0] flit_len_s;
   logic               flit_tail_s;

   assign wr_idx_s     = wr_ptr_q[PTR_W-1:0];
   assign rd_idx_s     = rd_ptr_q[PTR_W-1:0];
   assign cur_dest_s   = tbl_dest_q[rd_idx_s];
   assign cur_vc_s     = tbl_vc_q[rd_idx_s];
   assign cur_nflits_s = tbl_nflits_q[rd_idx_s];

   assign fill_req_s    = (state_q == ST_LOAD) && fill_valid_i && !init_i;
   assign fill_acc_s    = fill_req_s && (wr_ptr_q != DEPTH_P);
   assign fill_ovf_s    = fill_req_s && (wr_ptr_q == DEPTH_P);
   assign fill_bad_vc_s = fill_acc_s && ({1'b0, fill_vc_i} >= NUM_VC_W);
   assign fill_vc_s     = fill_bad_vc_s ? '0 : fill_vc_i;
   assign fill_nflits_s = (fill_nflits_i == '0) ? ONE_N : fill_nflits_i;

   // The first load is issued in the start cycle so out_valid rises right after start.
   assign credit_ok_s   = (credit_cnt_s[cur_vc_s] != '0);
   assign accept_s      = out_valid_q && out_ready_i;
   assign tail_acc_s    = accept_s && out_flit_q[TAIL_B];
   assign pkts_remain_s = (rd_ptr_q < wr_ptr_q);
   assign send_en_s     = (state_q == ST_SEND) || ((state_q == ST_LOAD) && start_i);
   assign load_s        = send_en_s && !init_i && (!out_valid_q || out_ready_i)
                          && pkts_remain_s && credit_ok_s;

   assign new_pkt_s   = (flits_left_q == '0);
   assign flit_len_s  = new_pkt_s ? cur_nflits_s : flits_left_q;
   assign flit_tail_s = (flit_len_s == ONE_N);

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      assign credit_dec_s[v] = load_s && (cur_vc_s == VC_W'(v));
      vc_credit_ctr #(
         .CREDITS (CREDITS),
         .CR_W    (CR_W)
      ) u_credit (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .clr_i   (init_i),
         .dec_i   (credit_dec_s[v]),
         .inc_i   (credit_ret_i[v]),
         .count_o (credit_cnt_s[v]),
         .ovf_o   (credit_ovf_s[v])
      );
   end

   // Packet table write; contents survive rst and init
   always_ff @(posedge clk_i) begin
      if (fill_acc_s) begin
         tbl_dest_q[wr_idx_s]   <= fill_dest_i;
         tbl_vc_q[wr_idx_s]     <= fill_vc_s;
         tbl_nflits_q[wr_idx_s] <= fill_nflits_s;
      end
   end

   // Next-state, pointers, flit register and flags
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      flits_left_d = flits_left_q;
      out_valid_d  = out_valid_q;
      out_flit_d   = out_flit_q;
      pkts_sent_d  = pkts_sent_q;
      err_d        = err_q;
      if (init_i) begin
         state_d      = ST_LOAD;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         flits_left_d = '0;
         out_valid_d  = 1'b0;
         out_flit_d   = '0;
         pkts_sent_d  = '0;
         err_d        = 1'b0;
      end else begin
         err_d = err_q | fill_ovf_s | fill_bad_vc_s | (|credit_ovf_s);
         if (fill_acc_s) begin
            wr_ptr_d = wr_ptr_q + ONE_P;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (load_s) begin
            out_valid_d  = 1'b1;
            out_flit_d   = {new_pkt_s, flit_tail_s, cur_vc_s, cur_dest_s};
            flits_left_d = flit_len_s - ONE_N;
            if (flit_tail_s) begin
               rd_ptr_d = rd_ptr_q + ONE_P;
            end else begin
               rd_ptr_d = rd_ptr_q;
            end
         end else if (accept_s) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
         if (tail_acc_s) begin
            pkts_sent_d = pkts_sent_q + ONE_P;
         end else begin
            pkts_sent_d = pkts_sent_q;
         end
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_LOAD: begin
               if (start_i) begin
                  state_d = (wr_ptr_d == '0) ? ST_DONE : ST_SEND;
               end else begin
                  state_d = ST_LOAD;
               end
            end
            ST_SEND: begin
               if (tail_acc_s && (pkts_sent_d == wr_ptr_q)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SEND;
               end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         flits_left_q <= '0;
         out_valid_q  <= 1'b0;
         out_flit_q   <= '0;
         pkts_sent_q  <= '0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         flits_left_q <= flits_left_d;
         out_valid_q  <= out_valid_d;
         out_flit_q   <= out_flit_d;
         pkts_sent_q  <= pkts_sent_d;
         err_q        <= err_d;
         busy_q       <= (state_d == ST_SEND);
         done_q       <= (state_d == ST_DONE);
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_flit_o  = out_flit_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pkts_sent_o = pkts_sent_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_traffic_src_vc.sv
// Directed bench for traffic_src_vc: a DEPTH=16/NUM_VC=4 instance for the main
// scenarios and a NUM_VC=5 instance so that an out-of-range VC can be driven.
module tb_traffic_src_vc;

   localparam int DEPTH   = 16;
   localparam int DEST_W  = 14;
   localparam int NUM_VC  = 4;
   localparam int NFLIT_W = 10;
   localparam int VC_W    = 2;
   localparam int PTR_W   = 4;
   localparam int FLIT_W  = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst = 1'b1;
   logic               init = 1'b0;
   logic               fill_valid = 1'b0;
   logic [DEST_W-1:0]  fill_dest = '0;
   logic [VC_W-1:0]    fill_vc = '0;
   logic [NFLIT_W-1:0] fill_nflits = '0;
   logic               start = 1'b0;
   logic               out_ready = 1'b0;
   logic [NUM_VC-1:0]  credit_ret = '0;
   logic               out_valid, busy, done, err;
   logic [FLIT_W-1:0]  out_flit;
   logic [PTR_W:0]     pkts_sent;

   logic               b_init = 1'b0;
   logic               b_fill_valid = 1'b0;
   logic [DEST_W-1:0]  b_fill_dest = '0;
   logic [2:0]         b_fill_vc = '0;
   logic [NFLIT_W-1:0] b_fill_nflits = '0;
   logic               b_start = 1'b0;
   logic               b_out_ready = 1'b0;
   logic [4:0]         b_credit_ret = '0;
   logic               b_out_valid, b_busy, b_done, b_err;
   logic [18:0]        b_out_flit;
   logic [2:0]         b_pkts_sent;

   int checks = 0;
   int failures = 0;

   traffic_src_vc #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .init_i(init), .fill_valid_i(fill_valid),
      .fill_dest_i(fill_dest), .fill_vc_i(fill_vc), .fill_nflits_i(fill_nflits),
      .start_i(start), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_flit_o(out_flit), .credit_ret_i(credit_ret), .busy_o(busy),
      .done_o(done), .pkts_sent_o(pkts_sent), .err_o(err)
   );

   traffic_src_vc #(.DEPTH(4), .NUM_VC(5)) dut5 (
      .clk_i(clk), .rst_i(rst), .init_i(b_init), .fill_valid_i(b_fill_valid),
      .fill_dest_i(b_fill_dest), .fill_vc_i(b_fill_vc), .fill_nflits_i(b_fill_nflits),
      .start_i(b_start), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
      .out_flit_o(b_out_flit), .credit_ret_i(b_credit_ret), .busy_o(b_busy),
      .done_o(b_done), .pkts_sent_o(b_pkts_sent), .err_o(b_err)
   );

   function automatic logic [FLIT_W-1:0] mk_flit(input logic h, input logic t,
                                                 input int vc, input int dest);
      logic [VC_W-1:0]   v;
      logic [DEST_W-1:0] d;
      v = VC_W'(vc);
      d = DEST_W'(dest);
      return {h, t, v, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init();
      init = 1'b1;
      step();
      init = 1'b0;
   endtask

   task automatic fill_pkt(input int d, input int v, input int n);
      fill_valid  = 1'b1;
      fill_dest   = DEST_W'(d);
      fill_vc     = VC_W'(v);
      fill_nflits = NFLIT_W'(n);
      step();
      fill_valid  = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++;
      if ({out_valid, busy, done, err, pkts_sent, out_flit} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got v=%b b=%b d=%b e=%b p=%0d f=%h, want all 0",
                  out_valid, busy, done, err, pkts_sent, out_flit);
      end
      checks++;
      if ({b_out_valid, b_busy, b_done, b_err, b_pkts_sent, b_out_flit} !== '0) begin
         failures++;
         $display("FAIL reset_outputs_vc5: got nonzero outputs, want all 0");
      end
   endtask

   task automatic test_basic();
      logic [FLIT_W-1:0] exp_f [6];
      int vcs [6];
      exp_f[0] = mk_flit(1'b1, 1'b0, 1, 5);  vcs[0] = 1;
      exp_f[1] = mk_flit(1'b0, 1'b0, 1, 5);  vcs[1] = 1;
      exp_f[2] = mk_flit(1'b0, 1'b1, 1, 5);  vcs[2] = 1;
      exp_f[3] = mk_flit(1'b1, 1'b1, 0, 9);  vcs[3] = 0;
      exp_f[4] = mk_flit(1'b1, 1'b0, 3, 2);  vcs[4] = 3;
      exp_f[5] = mk_flit(1'b0, 1'b1, 3, 2);  vcs[5] = 3;
      do_init();
      fill_pkt(5, 1, 3);
      fill_pkt(9, 0, 1);
      fill_pkt(2, 3, 2);
      out_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_flit !== exp_f[i]) begin
            failures++;
            $display("FAIL basic_flit%0d: got v=%b f=%h, want v=1 f=%h", i, out_valid, out_flit, exp_f[i]);
         end
         credit_ret = (i > 0) ? NUM_VC'(1 << vcs[i-1]) : '0;
         step();
      end
      credit_ret = NUM_VC'(1 << vcs[5]);
      checks++;
      if ({out_valid, busy, done, pkts_sent} !== {1'b0, 1'b0, 1'b1, 5'd3}) begin
         failures++;
         $display("FAIL basic_done: got v=%b b=%b d=%b p=%0d, want v=0 b=0 d=1 p=3",
                  out_valid, busy, done, pkts_sent);
      end
      step();
      credit_ret = '0;
      step();
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL basic_err: got %b want 0", err);
      end
   endtask

   task automatic test_credit_stall();
      do_init();
      fill_pkt(7, 2, 6);
      out_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_flit !== mk_flit(i == 0, 1'b0, 2, 7)) begin
            failures++;
            $display("FAIL stall_flit%0d: got v=%b f=%h", i, out_valid, out_flit);
         end
         step();
      end
      step();
      step();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL stall_idle: got v=%b b=%b, want v=0 b=1", out_valid, busy);
      end
      credit_ret = 4'b0100;
      step();
      credit_ret = '0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_flit !== mk_flit(1'b0, 1'b0, 2, 7)) begin
         failures++;
         $display("FAIL stall_flit4: got v=%b f=%h, want body flit", out_valid, out_flit);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stall_again: got v=%b want 0", out_valid);
      end
      credit_ret = 4'b0100;
      step();
      credit_ret = '0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_flit !== mk_flit(1'b0, 1'b1, 2, 7)) begin
         failures++;
         $display("FAIL stall_flit5: got v=%b f=%h, want tail flit", out_valid, out_flit);
      end
      step();
      checks++;
      if (done !== 1'b1 || pkts_sent !== 5'd1) begin
         failures++;
         $display("FAIL stall_done: got d=%b p=%0d, want d=1 p=1", done, pkts_sent);
      end
   endtask

   task automatic test_hold();
      do_init();
      fill_pkt(3, 0, 2);
      out_ready = 1'b0;
      pulse_start();
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_flit !== mk_flit(1'b1, 1'b0, 0, 3)) begin
            failures++;
            $display("FAIL hold_cycle%0d: got v=%b f=%h, want head flit held", k, out_valid, out_flit);
         end
         if (k < 5) step();
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_flit !== mk_flit(1'b0, 1'b1, 0, 3)) begin
         failures++;
         $display("FAIL hold_tail: got v=%b f=%h", out_valid, out_flit);
      end
      step();
      credit_ret = 4'b0001;
      step();
      step();
      credit_ret = '0;
      checks++;
      if (done !== 1'b1 || err !== 1'b0) begin
         failures++;
         $display("FAIL hold_credits: got d=%b e=%b, want d=1 e=0", done, err);
      end
      credit_ret = 4'b0001;
      step();
      credit_ret = '0;
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL hold_overflow: got err=%b want 1", err);
      end
   endtask

   task automatic test_errors();
      int nfl;
      int cyc;
      do_init();
      credit_ret = 4'b0001;
      step();
      credit_ret = '0;
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL credit_overflow_err: got %b want 1", err);
      end
      for (int i = 0; i < 5; i++) fill_pkt(20 + i, 0, 1);
      out_ready = 1'b1;
      pulse_start();
      nfl = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid === 1'b1) nfl++;
         step();
      end
      checks++;
      if (nfl !== 4) begin
         failures++;
         $display("FAIL credit_saturate: got %0d flits want 4", nfl);
      end

      do_init();
      for (int i = 0; i < DEPTH; i++) fill_pkt(100 + i, i % 4, 1);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL fill_full_noerr: got %b want 0", err);
      end
      fill_pkt(999, 0, 1);
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL fill_overflow_err: got %b want 1", err);
      end
      pulse_start();
      nfl = 0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 60) begin
         if (out_valid === 1'b1) nfl++;
         step();
         cyc++;
      end
      checks++;
      if (done !== 1'b1 || pkts_sent !== 5'd16 || nfl !== DEPTH) begin
         failures++;
         $display("FAIL fill_overflow_drain: got d=%b p=%0d flits=%0d, want d=1 p=16 flits=16",
                  done, pkts_sent, nfl);
      end

      b_init = 1'b1;
      step();
      b_init = 1'b0;
      b_fill_valid = 1'b1;
      b_fill_dest = 14'd21;
      b_fill_vc = 3'd5;
      b_fill_nflits = 10'd1;
      step();
      b_fill_valid = 1'b0;
      checks++;
      if (b_err !== 1'b1) begin
         failures++;
         $display("FAIL bad_vc_err: got %b want 1", b_err);
      end
      b_out_ready = 1'b1;
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      checks++;
      if (b_out_valid !== 1'b1 || b_out_flit !== {1'b1, 1'b1, 3'd0, 14'd21}) begin
         failures++;
         $display("FAIL bad_vc_stored0: got v=%b f=%h want v=1 f=%h",
                  b_out_valid, b_out_flit, {1'b1, 1'b1, 3'd0, 14'd21});
      end
   endtask

   task automatic test_abort();
      do_init();
      fill_pkt(11, 1, 4);
      out_ready = 1'b1;
      pulse_start();
      step();
      checks++;
      if (out_valid !== 1'b1 || out_flit !== mk_flit(1'b0, 1'b0, 1, 11)) begin
         failures++;
         $display("FAIL abort_second_flit: got v=%b f=%h", out_valid, out_flit);
      end
      do_init();
      checks++;
      if ({out_valid, busy, done, pkts_sent, out_flit} !== '0) begin
         failures++;
         $display("FAIL abort_init: got v=%b b=%b d=%b p=%0d f=%h, want all 0",
                  out_valid, busy, done, pkts_sent, out_flit);
      end
      credit_ret = 4'b0010;
      step();
      credit_ret = '0;
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL abort_credits_restored: got err=%b want 1", err);
      end
      do_init();
      fill_pkt(4, 1, 1);
      pulse_start();
      checks++;
      if (out_valid !== 1'b1 || out_flit !== mk_flit(1'b1, 1'b1, 1, 4)) begin
         failures++;
         $display("FAIL abort_reload: got v=%b f=%h", out_valid, out_flit);
      end

      do_init();
      fill_pkt(8, 2, 4);
      pulse_start();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({out_valid, busy, done, err, pkts_sent, out_flit} !== '0) begin
         failures++;
         $display("FAIL abort_rst: got v=%b b=%b d=%b e=%b p=%0d f=%h, want all 0",
                  out_valid, busy, done, err, pkts_sent, out_flit);
      end
      pulse_start();
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_ignores_start: got d=%b v=%b want 0 0", done, out_valid);
      end
   endtask

   task automatic test_edge();
      do_init();
      out_ready = 1'b1;
      pulse_start();
      checks++;
      if ({done, busy, out_valid} !== 3'b100) begin
         failures++;
         $display("FAIL empty_start: got d=%b b=%b v=%b, want 1 0 0", done, busy, out_valid);
      end
      step();
      step();
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL empty_stays: got v=%b d=%b want 0 1", out_valid, done);
      end
      do_init();
      fill_pkt(6, 2, 0);
      pulse_start();
      checks++;
      if (out_valid !== 1'b1 || out_flit !== mk_flit(1'b1, 1'b1, 2, 6)) begin
         failures++;
         $display("FAIL zero_nflits: got v=%b f=%h want v=1 f=%h",
                  out_valid, out_flit, mk_flit(1'b1, 1'b1, 2, 6));
      end
      step();
      checks++;
      if ({done, out_valid, pkts_sent} !== {1'b1, 1'b0, 5'd1}) begin
         failures++;
         $display("FAIL zero_nflits_done: got d=%b v=%b p=%0d want 1 0 1", done, out_valid, pkts_sent);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_credit_stall();
      test_hold();
      test_errors();
      test_abort();
      test_edge();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
